// File: rtl/branch_resolve_stage_pkg.sv
// Shared BPF jump / PC-select encodings and perf counter indices for the branch resolve stage.
package branch_resolve_stage_pkg;
  localparam logic [2:0] JMP_NONE = 3'd0;
  localparam logic [2:0] BPF_JA   = 3'd1;
  localparam logic [2:0] BPF_JEQ  = 3'd2;
  localparam logic [2:0] BPF_JGT  = 3'd3;
  localparam logic [2:0] BPF_JGE  = 3'd4;
  localparam logic [2:0] BPF_JSET = 3'd5;

  // Zero is reserved so stages can OR their PC_sel outputs together.
  localparam logic [2:0] PC_SEL_NONE     = 3'd0;
  localparam logic [2:0] PC_SEL_PLUS_1   = 3'd1;
  localparam logic [2:0] PC_SEL_PLUS_IMM = 3'd2;
  localparam logic [2:0] PC_SEL_PLUS_JT  = 3'd3;
  localparam logic [2:0] PC_SEL_PLUS_JF  = 3'd4;

  localparam int PERF_NUM     = 3;
  localparam int PERF_RETIRED = 0;
  localparam int PERF_TAKEN   = 1;
  localparam int PERF_STALL   = 2;
endpackage

// File: rtl/branch_resolve_stage_if.sv
// Stage 1 -> stage 2 decoded-instruction handshake.
interface branch_resolve_stage_if #(
  parameter int ALU_SEL_W = 4,
  parameter int SEL_W     = 3,
  parameter int OFF_W     = 8
);
  logic                 valid_in;
  logic                 ready_out;
  logic [ALU_SEL_W-1:0] ALU_sel_in;
  logic [2:0]           jmp_type;
  logic [OFF_W-1:0]     jt_in, jf_in;
  logic                 PC_en_in, packet_mem_rd_en_in, regfile_wr_en_in, A_en_in, X_en_in;
  logic [1:0]           transfer_sz_in;
  logic                 regfile_sel_in;
  logic [SEL_W-1:0]     A_sel_in, X_sel_in;

  modport master (
    output valid_in, ALU_sel_in, jmp_type, jt_in, jf_in, PC_en_in, packet_mem_rd_en_in,
           regfile_wr_en_in, A_en_in, X_en_in, transfer_sz_in, regfile_sel_in, A_sel_in, X_sel_in,
    input  ready_out
  );
  modport slave (
    input  valid_in, ALU_sel_in, jmp_type, jt_in, jf_in, PC_en_in, packet_mem_rd_en_in,
           regfile_wr_en_in, A_en_in, X_en_in, transfer_sz_in, regfile_sel_in, A_sel_in, X_sel_in,
    output ready_out
  );
endinterface

// File: rtl/branch_resolve_stage_perf.sv
// Saturating event counters for the branch resolve stage (used only with BRS_PERF_EN).
module brs_perf_counters #(
  parameter int CNT_W = 32,
  parameter int NUM   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM-1:0]            inc,
  output logic [NUM-1:0][CNT_W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else
      for (int i = 0; i < NUM; i++)
        if (inc[i] && (cnt[i] != {CNT_W{1'b1}})) cnt[i] <= cnt[i] + CNT_W'(1);
  end
endmodule

// File: rtl/branch_resolve_stage.sv
// BPF stage 2: one-entry output slot, jump resolution from ALU flags, redirect flush/shadow squash.
// Optional perf counters under BRS_PERF_EN.
module branch_resolve_stage
  import branch_resolve_stage_pkg::*;
#(
  parameter int ALU_SEL_W    = 4,
  parameter int SEL_W        = 3,
  parameter int OFF_W        = 8,
  parameter int SHADOW_DEPTH = 2
`ifdef BRS_PERF_EN
  , parameter int CNT_W      = 32
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 eq, gt, ge, set,
  branch_resolve_stage_if.slave up,
  input  logic                 stage3_ready,
  output logic [ALU_SEL_W-1:0] ALU_sel,
  output logic [1:0]           transfer_sz,
  output logic                 regfile_sel,
  output logic [SEL_W-1:0]     A_sel_out, X_sel_out,
  output logic                 PC_en, packet_mem_rd_en, regfile_wr_en, A_en_out, X_en_out,
  output logic [2:0]           PC_sel,
  output logic                 valid,
  output logic                 flush
`ifdef BRS_PERF_EN
  , output logic [CNT_W-1:0]   perf_retired, perf_taken, perf_stall
`endif
);
  localparam logic [2:0] SHADOW_INIT = 3'(SHADOW_DEPTH);

  logic             slot_valid;
  logic [2:0]       jmp_q;
  logic [OFF_W-1:0] jt_q, jf_q;
  logic             pc_en_q, pm_rd_q, rf_wr_q, a_en_q, x_en_q;
  logic [2:0]       squash_cnt;
  logic [2:0]       sel_raw;
  logic             fire, accept, load;

  assign up.ready_out = !slot_valid || stage3_ready;
  assign accept       = up.valid_in && up.ready_out;
  // A flush-cycle arrival is dropped without consuming the shadow.
  assign load         = accept && (squash_cnt == 3'd0) && !flush;
  assign valid        = slot_valid;

  always @(*) begin
    sel_raw = PC_SEL_PLUS_1;
    case (jmp_q)
      BPF_JA:   sel_raw = PC_SEL_PLUS_IMM;
      BPF_JEQ:  sel_raw = eq  ? PC_SEL_PLUS_JT : PC_SEL_PLUS_JF;
      BPF_JGT:  sel_raw = gt  ? PC_SEL_PLUS_JT : PC_SEL_PLUS_JF;
      BPF_JGE:  sel_raw = ge  ? PC_SEL_PLUS_JT : PC_SEL_PLUS_JF;
      BPF_JSET: sel_raw = set ? PC_SEL_PLUS_JT : PC_SEL_PLUS_JF;
      default:  sel_raw = PC_SEL_PLUS_1;
    endcase
    fire             = slot_valid && stage3_ready;
    PC_en            = pc_en_q && fire;
    packet_mem_rd_en = pm_rd_q && fire;
    regfile_wr_en    = rf_wr_q && fire;
    A_en_out         = a_en_q  && fire;
    X_en_out         = x_en_q  && fire;
    PC_sel           = PC_en ? sel_raw : PC_SEL_NONE;
    // A zero offset lands on the next instruction, so no redirect is needed.
    flush            = PC_en && ((jmp_q == BPF_JA) ||
                                 ((sel_raw == PC_SEL_PLUS_JT) && (jt_q != '0)) ||
                                 ((sel_raw == PC_SEL_PLUS_JF) && (jf_q != '0)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid  <= 1'b0;
      squash_cnt  <= 3'd0;
      jmp_q       <= JMP_NONE;
      jt_q        <= '0;
      jf_q        <= '0;
      pc_en_q     <= 1'b0;
      pm_rd_q     <= 1'b0;
      rf_wr_q     <= 1'b0;
      a_en_q      <= 1'b0;
      x_en_q      <= 1'b0;
      ALU_sel     <= '0;
      transfer_sz <= '0;
      regfile_sel <= 1'b0;
      A_sel_out   <= '0;
      X_sel_out   <= '0;
    end else begin
      if (load) begin
        slot_valid  <= 1'b1;
        jmp_q       <= up.jmp_type;
        jt_q        <= up.jt_in;
        jf_q        <= up.jf_in;
        pc_en_q     <= up.PC_en_in;
        pm_rd_q     <= up.packet_mem_rd_en_in;
        rf_wr_q     <= up.regfile_wr_en_in;
        a_en_q      <= up.A_en_in;
        x_en_q      <= up.X_en_in;
        ALU_sel     <= up.ALU_sel_in;
        transfer_sz <= up.transfer_sz_in;
        regfile_sel <= up.regfile_sel_in;
        A_sel_out   <= up.A_sel_in;
        X_sel_out   <= up.X_sel_in;
      end else if (fire) begin
        slot_valid  <= 1'b0;
      end
      if (flush)                             squash_cnt <= SHADOW_INIT;
      else if (accept && squash_cnt != 3'd0) squash_cnt <= squash_cnt - 3'd1;
    end
  end

`ifdef BRS_PERF_EN
  logic [PERF_NUM-1:0]            perf_inc;
  logic [PERF_NUM-1:0][CNT_W-1:0] perf_cnt;

  assign perf_inc[PERF_RETIRED] = fire;
  assign perf_inc[PERF_TAKEN]   = flush;
  assign perf_inc[PERF_STALL]   = slot_valid && !stage3_ready;

  brs_perf_counters #(.CNT_W(CNT_W), .NUM(PERF_NUM)) u_perf (
    .clk (clk),
    .rst (rst),
    .inc (perf_inc),
    .cnt (perf_cnt)
  );

  assign perf_retired = perf_cnt[PERF_RETIRED];
  assign perf_taken   = perf_cnt[PERF_TAKEN];
  assign perf_stall   = perf_cnt[PERF_STALL];
`endif
endmodule

// File: tb/tb_branch_resolve_stage.sv
// Directed scoreboard bench for branch_resolve_stage: expected slot contents are queued on accept
// and compared when the slot fires; a small squash model decides which accepts are loaded.
module tb_branch_resolve_stage;
  import branch_resolve_stage_pkg::*;

  localparam int SD = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       eq, gt, ge, set, stage3_ready;
  logic [3:0] ALU_sel;
  logic [1:0] transfer_sz;
  logic       regfile_sel;
  logic [2:0] A_sel_out, X_sel_out;
  logic       PC_en, packet_mem_rd_en, regfile_wr_en, A_en_out, X_en_out;
  logic [2:0] PC_sel;
  logic       valid, flush;
`ifdef BRS_PERF_EN
  logic [31:0] perf_retired, perf_taken, perf_stall;
  logic [31:0] stall_base;
`endif

  branch_resolve_stage_if #(.ALU_SEL_W(4), .SEL_W(3), .OFF_W(8)) up ();

  branch_resolve_stage #(.ALU_SEL_W(4), .SEL_W(3), .OFF_W(8), .SHADOW_DEPTH(SD)) dut (
    .clk(clk), .rst(rst), .eq(eq), .gt(gt), .ge(ge), .set(set), .up(up),
    .stage3_ready(stage3_ready), .ALU_sel(ALU_sel), .transfer_sz(transfer_sz),
    .regfile_sel(regfile_sel), .A_sel_out(A_sel_out), .X_sel_out(X_sel_out), .PC_en(PC_en),
    .packet_mem_rd_en(packet_mem_rd_en), .regfile_wr_en(regfile_wr_en), .A_en_out(A_en_out),
    .X_en_out(X_en_out), .PC_sel(PC_sel), .valid(valid), .flush(flush)
`ifdef BRS_PERF_EN
    , .perf_retired(perf_retired), .perf_taken(perf_taken), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] alu;
    logic       pc_en;
    logic [2:0] pc_sel;
    logic       flush;
    logic       rf_wr;
    logic [1:0] tsz;
    logic [2:0] a_sel;
    logic [2:0] x_sel;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0, sq = 0, fires = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic [2:0] jmp, input logic [7:0] jt, input logic [7:0] jf,
                       input logic [3:0] alu, input logic pce = 1'b1);
    up.valid_in            = 1'b1;
    up.jmp_type            = jmp;
    up.jt_in               = jt;
    up.jf_in               = jf;
    up.ALU_sel_in          = alu;
    up.PC_en_in            = pce;
    up.regfile_wr_en_in    = alu[0];
    up.packet_mem_rd_en_in = alu[1];
    up.A_en_in             = alu[2];
    up.X_en_in             = alu[3];
    up.transfer_sz_in      = alu[1:0];
    up.regfile_sel_in      = alu[3];
    up.A_sel_in            = alu[2:0];
    up.X_sel_in            = ~alu[2:0];
  endtask

  task automatic idle();
    up.valid_in = 1'b0;
  endtask

  // Expected slot behaviour for the instruction currently on the input, with the current flags.
  function automatic exp_t mk();
    exp_t e;
    logic [2:0] s;
    case (up.jmp_type)
      BPF_JA:   s = PC_SEL_PLUS_IMM;
      BPF_JEQ:  s = eq  ? PC_SEL_PLUS_JT : PC_SEL_PLUS_JF;
      BPF_JGT:  s = gt  ? PC_SEL_PLUS_JT : PC_SEL_PLUS_JF;
      BPF_JGE:  s = ge  ? PC_SEL_PLUS_JT : PC_SEL_PLUS_JF;
      BPF_JSET: s = set ? PC_SEL_PLUS_JT : PC_SEL_PLUS_JF;
      default:  s = PC_SEL_PLUS_1;
    endcase
    e.alu    = up.ALU_sel_in;
    e.pc_en  = up.PC_en_in;
    e.pc_sel = e.pc_en ? s : 3'd0;
    e.flush  = e.pc_en && ((up.jmp_type == BPF_JA) ||
                           ((s == PC_SEL_PLUS_JT) && (up.jt_in != 8'd0)) ||
                           ((s == PC_SEL_PLUS_JF) && (up.jf_in != 8'd0)));
    e.rf_wr  = up.regfile_wr_en_in;
    e.tsz    = up.transfer_sz_in;
    e.a_sel  = up.A_sel_in;
    e.x_sel  = up.X_sel_in;
    return e;
  endfunction

  // One clock: check outputs against the queued slot, update the model, advance past the edge.
  task automatic cycle();
    exp_t e;
    logic exp_v, exp_rdy, exp_fire, exp_fl;
    #1;
    exp_v    = (sb.size() != 0);
    exp_fire = exp_v && stage3_ready;
    exp_rdy  = !exp_v || stage3_ready;
    exp_fl   = 1'b0;
    chk("valid", 32'(valid), 32'(exp_v));
    chk("ready_out", 32'(up.ready_out), 32'(exp_rdy));
    if (exp_v) begin
      chk("alu_sel", 32'(ALU_sel), 32'(sb[0].alu));
      chk("a_sel", 32'(A_sel_out), 32'(sb[0].a_sel));
      chk("x_sel", 32'(X_sel_out), 32'(sb[0].x_sel));
      chk("transfer_sz", 32'(transfer_sz), 32'(sb[0].tsz));
    end
    if (exp_fire) begin
      e = sb.pop_front();
      fires++;
      chk("pc_en", 32'(PC_en), 32'(e.pc_en));
      chk("pc_sel", 32'(PC_sel), 32'(e.pc_sel));
      chk("flush", 32'(flush), 32'(e.flush));
      chk("regfile_wr_en", 32'(regfile_wr_en), 32'(e.rf_wr));
      exp_fl = e.flush;
    end else begin
      chk("pc_en_idle", 32'(PC_en), 32'd0);
      chk("regfile_wr_idle", 32'(regfile_wr_en), 32'd0);
      chk("pc_sel_idle", 32'(PC_sel), 32'd0);
      chk("flush_idle", 32'(flush), 32'd0);
    end
    if (up.valid_in && exp_rdy && !exp_fl) begin
      if (sq != 0) sq--;
      else         sb.push_back(mk());
    end
    if (exp_fl) sq = SD;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {eq, gt, ge, set} = 4'b0;
    stage3_ready = 1'b0;
    instr(JMP_NONE, 8'd0, 8'd0, 4'd0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    // 1: reset state
    chk("rst_ready_out", 32'(up.ready_out), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_pc_en", 32'(PC_en), 32'd0);
    chk("rst_pc_sel", 32'(PC_sel), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    rst = 1'b0;
    stage3_ready = 1'b1;
    cycle();

    // 2: JEQ taken with jt=3 -> flush; flush-cycle arrival plus 2 more dropped, 3rd loads
    eq = 1'b1;
    instr(BPF_JEQ, 8'd3, 8'd5, 4'h1); cycle();
    instr(JMP_NONE, 8'd0, 8'd0, 4'h2); cycle();
    eq = 1'b0;
    instr(JMP_NONE, 8'd0, 8'd0, 4'h3); cycle();
    instr(JMP_NONE, 8'd0, 8'd0, 4'h4); cycle();
    instr(JMP_NONE, 8'd0, 8'd0, 4'h5); cycle();
    idle(); cycle();
    chk("jeq_shadow_len", 32'(fires), 32'd2);

    // 3: JGT not taken with jf=0 -> PLUS_JF, no flush, next loads normally
    gt = 1'b0;
    instr(BPF_JGT, 8'd7, 8'd0, 4'h6); cycle();
    instr(JMP_NONE, 8'd0, 8'd0, 4'h7); cycle();
    // further patterns: JGE taken jt=0, JSET taken jt=0, undefined code, jump with PC_en=0
    ge = 1'b1; set = 1'b1;
    instr(BPF_JGE, 8'd0, 8'd4, 4'h8); cycle();
    instr(BPF_JSET, 8'd0, 8'd9, 4'h9); cycle();
    instr(3'd7, 8'd2, 8'd2, 4'hA); cycle();
    eq = 1'b1;
    instr(BPF_JEQ, 8'd3, 8'd3, 4'hB, 1'b0); cycle();
    idle(); cycle();
    {eq, gt, ge, set} = 4'b0;
    cycle();

    // 4: four stall cycles with the slot full; a waiting instruction must not be accepted
`ifdef BRS_PERF_EN
    stall_base = perf_stall;
`endif
    stage3_ready = 1'b0;
    instr(JMP_NONE, 8'd0, 8'd0, 4'hD); cycle();
    instr(JMP_NONE, 8'd0, 8'd0, 4'h3);
    repeat (4) cycle();
    stage3_ready = 1'b1;
    cycle();
    idle(); cycle();
`ifdef BRS_PERF_EN
    chk("perf_stall", perf_stall - stall_base, 32'd4);
`endif

    // 5: ten back-to-back ALU ops
    cycle();
    fires = 0;
    for (int i = 0; i < 10; i++) begin
      instr(JMP_NONE, 8'd0, 8'd0, 4'(i + 3));
      cycle();
    end
    idle(); cycle();
    chk("b2b_fires", 32'(fires), 32'd10);

    // 6a: asynchronous reset with the slot full
    stage3_ready = 1'b0;
    instr(JMP_NONE, 8'd0, 8'd0, 4'hF); cycle();
    idle();
    stage3_ready = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_pc_en", 32'(PC_en), 32'd0);
    chk("arst_ready_out", 32'(up.ready_out), 32'd1);
    sb.delete();
    sq = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 6b: reset while one shadow slot is still pending; first post-reset instruction loads
    instr(BPF_JA, 8'd0, 8'd0, 4'hC); cycle();
    instr(JMP_NONE, 8'd0, 8'd0, 4'h1); cycle();
    instr(JMP_NONE, 8'd0, 8'd0, 4'h2); cycle();
    idle();
    rst = 1'b1;
    #1;
    chk("arst2_valid", 32'(valid), 32'd0);
    chk("arst2_flush", 32'(flush), 32'd0);
    sb.delete();
    sq = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fires = 0;
    instr(JMP_NONE, 8'd0, 8'd0, 4'h6); cycle();
    idle(); cycle();
    chk("post_rst_load", 32'(fires), 32'd1);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
